// File: rtl/check_phrase_seq.sv
// check_phrase_seq: matches a stored phrase against two character streams and emits each matched character
// Ports:
//    clk, rst_n             - clock, asynchronous active-low reset
//    en                     - run enable; 0 selects idle and pattern-load mode
//    pat_we/pat_addr/pat_data - pattern RAM write port, accepted only in IDLE with en=0
//    pat_len                - active phrase length, latched on the rising edge of en
//    cap_flow/cap_valid     - uppercase character stream
//    low_flow/low_valid     - lowercase/other character stream
//    out_flow/out_valid     - registered emitted character and its one-cycle strobe
//    done, abort            - one-cycle pulses for phrase complete / stall timeout
//    match_cnt              - saturating count of completed phrases
// Define CHECK_PHRASE_SEQ_TIMEOUT_EN to enable the inter-character stall timeout.
module check_phrase_seq #(
   parameter int MAX_LEN = 16,
   parameter int CNT_W   = 16,
   parameter int TIMEOUT = 1024
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         en,
   input  logic                         pat_we,
   input  logic [$clog2(MAX_LEN)-1:0]   pat_addr,
   input  logic [7:0]                   pat_data,
   input  logic [$clog2(MAX_LEN+1)-1:0] pat_len,
   input  logic [7:0]                   cap_flow,
   input  logic                         cap_valid,
   input  logic [7:0]                   low_flow,
   input  logic                         low_valid,
   output logic [7:0]                   out_flow,
   output logic                         out_valid,
   output logic                         done,
   output logic                         abort,
   output logic [CNT_W-1:0]             match_cnt
);
   localparam int IW = $clog2(MAX_LEN);
   localparam int LW = $clog2(MAX_LEN+1);

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   state_t           state_q, state_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic [LW-1:0]    len_q, len_d, eff_len;
   logic [7:0]       pat_q [MAX_LEN];
   logic [7:0]       pat_d [MAX_LEN];
   logic [7:0]       out_flow_q, out_flow_d, c;
   logic             out_valid_q, out_valid_d, done_q, done_d, en_q;
   logic             en_rise, hit, last;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign c       = pat_q[idx_q];
   assign en_rise = en & ~en_q;
   // The length captured on this very edge must already gate the IDLE->SCAN decision
   assign eff_len = en_rise ? pat_len : len_q;
   // A space element always advances; letters pick their stream by case
   assign hit     = (c == 8'h20) ||
                    ((c >= 8'h41 && c <= 8'h5A) ? (cap_valid && cap_flow == c)
                                                : (low_valid && low_flow == c));
   assign last    = (LW'(idx_q) + LW'(1)) == len_q;

`ifdef CHECK_PHRASE_SEQ_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT+1);
   logic [TW-1:0] tmo_q, tmo_d;
   logic          abort_q, abort_d;
   assign abort = abort_q;
`else
   assign abort = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      len_d       = en_rise ? pat_len : len_q;
      pat_d       = pat_q;
      out_flow_d  = out_flow_q;
      out_valid_d = 1'b0;
      done_d      = 1'b0;
      cnt_d       = cnt_q;
`ifdef CHECK_PHRASE_SEQ_TIMEOUT_EN
      tmo_d       = '0;
      abort_d     = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (pat_we && !en) pat_d[pat_addr] = pat_data;
            if (en && eff_len != '0 && eff_len <= LW'(MAX_LEN)) begin
               state_d = SCAN;
               idx_d   = '0;
            end
         end
         SCAN: begin
            if (!en) begin
               state_d = IDLE;
               idx_d   = '0;
            end else if (hit) begin
               out_flow_d  = c;
               out_valid_d = 1'b1;
               idx_d       = last ? '0 : idx_q + IW'(1);
               state_d     = last ? DONE : SCAN;
            end
`ifdef CHECK_PHRASE_SEQ_TIMEOUT_EN
            // Counts consecutive stalled cycles once at least one character has matched
            else if (idx_q != '0) begin
               if (tmo_q == TW'(TIMEOUT-1)) begin
                  idx_d   = '0;
                  abort_d = 1'b1;
               end else begin
                  tmo_d = tmo_q + TW'(1);
               end
            end
`endif
         end
         DONE: begin
            out_flow_d  = 8'h21;
            out_valid_d = 1'b1;
            done_d      = 1'b1;
            cnt_d       = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
            idx_d       = '0;
            state_d     = en ? SCAN : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         len_q       <= '0;
         en_q        <= 1'b0;
         out_flow_q  <= 8'h20;
         out_valid_q <= 1'b0;
         done_q      <= 1'b0;
         cnt_q       <= '0;
         for (int i = 0; i < MAX_LEN; i++) pat_q[i] <= 8'h00;
`ifdef CHECK_PHRASE_SEQ_TIMEOUT_EN
         tmo_q       <= '0;
         abort_q     <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         len_q       <= len_d;
         en_q        <= en;
         out_flow_q  <= out_flow_d;
         out_valid_q <= out_valid_d;
         done_q      <= done_d;
         cnt_q       <= cnt_d;
         pat_q       <= pat_d;
`ifdef CHECK_PHRASE_SEQ_TIMEOUT_EN
         tmo_q       <= tmo_d;
         abort_q     <= abort_d;
`endif
      end
   end

   assign out_flow  = out_flow_q;
   assign out_valid = out_valid_q;
   assign done      = done_q;
   assign match_cnt = cnt_q;
endmodule

// File: tb/tb_check_phrase_seq.sv
// tb_check_phrase_seq: directed self-checking bench for check_phrase_seq
module tb_check_phrase_seq;
   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         en = 1'b0;
   logic         pat_we = 1'b0;
   logic [3:0]   pat_addr = '0;
   logic [7:0]   pat_data = '0;
   logic [4:0]   pat_len = '0;
   logic [7:0]   cap_flow = '0;
   logic         cap_valid = 1'b0;
   logic [7:0]   low_flow = '0;
   logic         low_valid = 1'b0;
   logic [7:0]   out_flow;
   logic         out_valid, done, abort;
   logic [1:0]   match_cnt;

   int           checks = 0;
   int           errors = 0;
   int           nout, ndone, nabort;
   logic [127:0] obuf;

   check_phrase_seq #(.MAX_LEN(16), .CNT_W(2), .TIMEOUT(8)) dut (
      .clk(clk), .rst_n(rst_n), .en(en),
      .pat_we(pat_we), .pat_addr(pat_addr), .pat_data(pat_data), .pat_len(pat_len),
      .cap_flow(cap_flow), .cap_valid(cap_valid), .low_flow(low_flow), .low_valid(low_valid),
      .out_flow(out_flow), .out_valid(out_valid), .done(done), .abort(abort),
      .match_cnt(match_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (out_valid) begin
         obuf = {obuf[119:0], out_flow};
         nout++;
      end
      if (done) ndone++;
      if (abort) nabort++;
   endtask

   task automatic clr();
      obuf = '0;
      nout = 0;
      ndone = 0;
      nabort = 0;
   endtask

   task automatic idle();
      en = 1'b0;
      tick();
      tick();
   endtask

   task automatic load(input string s);
      for (int i = 0; i < s.len(); i++) begin
         pat_we   = 1'b1;
         pat_addr = 4'(i);
         pat_data = s[i];
         tick();
      end
      pat_we  = 1'b0;
      pat_len = 5'(s.len());
   endtask

   task automatic feed(input bit cap, input logic [7:0] ch, input int gap);
      bit ok = 1'b0;
      repeat (gap) tick();
      if (cap) begin
         cap_flow = ch; cap_valid = 1'b1;
      end else begin
         low_flow = ch; low_valid = 1'b1;
      end
      for (int k = 0; k < 8 && !ok; k++) begin
         tick();
         ok = out_valid && out_flow == ch;
      end
      cap_valid = 1'b0;
      low_valid = 1'b0;
      check($sformatf("feed_%0h", ch), {127'd0, ok}, 128'd1);
   endtask

   initial begin
      clr();
      repeat (2) tick();
      check("rst_out_flow", out_flow, 8'h20);
      check("rst_out_valid", out_valid, 0);
      check("rst_done", done, 0);
      check("rst_abort", abort, 0);
      check("rst_cnt", match_cnt, 0);
      rst_n = 1'b1;
      tick();

      // "I Love You" with gaps between characters
      load("I Love You");
      clr();
      en = 1'b1;
      feed(1, "I", 1); feed(1, "L", 2); feed(0, "o", 1); feed(0, "v", 3);
      feed(0, "e", 0); feed(1, "Y", 2); feed(0, "o", 1); feed(0, "u", 2);
      tick();
      check("ily_seq", obuf, "I Love You!");
      check("ily_done", ndone, 1);
      check("ily_cnt", match_cnt, 1);

      // wrong streams never match, right streams do
      idle();
      load("Ab");
      clr();
      en = 1'b1;
      cap_flow = "b"; cap_valid = 1'b1; low_flow = "A"; low_valid = 1'b1;
      repeat (5) tick();
      cap_valid = 1'b0; low_valid = 1'b0;
      check("ab_wrong_stream", nout, 0);
      feed(1, "A", 0); feed(0, "b", 1);
      tick();
      check("ab_seq", obuf, "Ab!");
      check("ab_cnt", match_cnt, 2);

      // a pattern write while running must not land
      pat_we = 1'b1; pat_addr = 4'd0; pat_data = "Z";
      tick();
      pat_we = 1'b0;
      clr();
      feed(1, "A", 0); feed(0, "b", 0);
      tick();
      check("we_ignored_seq", obuf, "Ab!");
      check("we_ignored_cnt", match_cnt, 3);

      // reset mid-phrase; en held so the scan restarts against the cleared RAM
      idle();
      load("abcd");
      clr();
      en = 1'b1;
      feed(0, "a", 0); feed(0, "b", 0); feed(0, "c", 0);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_flow", out_flow, 8'h20);
      check("mid_rst_valid", out_valid, 0);
      check("mid_rst_cnt", match_cnt, 0);
      tick();
      rst_n = 1'b1;
      clr();
      low_flow = "a"; low_valid = 1'b1;
      repeat (3) tick();
      low_valid = 1'b0;
      check("ram_cleared", nout, 0);
      repeat (4) feed(0, 8'h00, 0);
      tick();
      check("restart_seq", obuf, 128'h21);
      check("restart_nout", nout, 5);
      check("restart_cnt", match_cnt, 1);

      // all-space phrase runs without input
      idle();
      load("   ");
      clr();
      en = 1'b1;
      repeat (4) tick();
      en = 1'b0;
      tick();
      check("spaces_seq", obuf, "   !");
      check("spaces_nout", nout, 4);
      check("spaces_done", ndone, 1);
      check("spaces_cnt", match_cnt, 2);

      // dropping en mid-phrase abandons it silently
      idle();
      load("xyz");
      clr();
      en = 1'b1;
      feed(0, "x", 0); feed(0, "y", 0);
      en = 1'b0;
      repeat (2) tick();
      check("endrop_done", ndone, 0);
      check("endrop_cnt", match_cnt, 2);
      en = 1'b1;
      feed(0, "x", 0); feed(0, "y", 0); feed(0, "z", 0);
      tick();
      check("endrop_seq", obuf, "xyxyz!");
      check("endrop_cnt2", match_cnt, 3);

      // zero and oversize lengths stay idle
      idle();
      pat_len = 5'd0;
      clr();
      en = 1'b1;
      low_flow = "x"; low_valid = 1'b1;
      repeat (4) tick();
      en = 1'b0;
      tick();
      pat_len = 5'd17;
      en = 1'b1;
      repeat (4) tick();
      low_valid = 1'b0;
      check("bad_len_nout", nout, 0);

      // long stall after the first match
      idle();
      pat_len = 5'd3;
      clr();
      en = 1'b1;
      feed(0, "x", 1);
`ifdef CHECK_PHRASE_SEQ_TIMEOUT_EN
      repeat (8) tick();
      check("tmo_abort", nabort, 1);
      feed(0, "x", 0); feed(0, "y", 0); feed(0, "z", 0);
      tick();
      check("tmo_seq", obuf, "xxyz!");
`else
      repeat (100) tick();
      check("tmo_no_abort", nabort, 0);
      feed(0, "y", 0); feed(0, "z", 0);
      tick();
      check("tmo_seq", obuf, "xyz!");
`endif
      check("tmo_cnt_sat", match_cnt, 3);

      // one more phrase with the counter saturated
      clr();
      feed(0, "x", 0); feed(0, "y", 0); feed(0, "z", 0);
      tick();
      check("sat_done", ndone, 1);
      check("sat_cnt", match_cnt, 3);
      idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/check_phrase_seq.md
CHECK_PHRASE_SEQ -- requirements
Module: check_phrase_seq

Interface
REQ-001 SHALL have parameter MAX_LEN, default 16, meaning pattern storage depth in characters (2..64).
REQ-002 SHALL have parameter CNT_W, default 16, meaning width of match_cnt.
REQ-003 SHALL have parameter TIMEOUT, default 1024, meaning cycles allowed between consecutive matched characters.
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all state on rising edge.
REQ-005 SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-006 SHALL have port en, input, 1, meaning run enable; 0 means idle and pattern-load mode.
REQ-007 SHALL have ports pat_we, pat_addr, pat_data: input, 1 / clog2(MAX_LEN) / 8, meaning pattern RAM write.
REQ-008 SHALL have port pat_len, input, clog2(MAX_LEN+1), meaning active pattern length; sampled on en 0->1.
REQ-009 SHALL have ports cap_flow, cap_valid: input, 8 / 1, meaning uppercase character stream.
REQ-010 SHALL have ports low_flow, low_valid: input, 8 / 1, meaning lowercase/other character stream.
REQ-011 SHALL have ports out_flow, out_valid: output, 8 / 1, meaning emitted character and its 1-cycle strobe.
REQ-012 SHALL have ports done, abort: output, 1 each, meaning 1-cycle pulses for phrase complete and timeout abort.
REQ-013 SHALL have port match_cnt, output, CNT_W, meaning count of completed phrases, saturating.

Function
REQ-014 SHALL implement states IDLE, SCAN, DONE.
REQ-015 In IDLE, SHALL write pattern RAM at pat_addr when pat_we=1; writes while en=1 SHALL be ignored.
REQ-016 IDLE->SCAN on en=1 with latched length L>=1: idx=0; L=0 or L>MAX_LEN stays IDLE.
REQ-017 In SCAN, element c=pat[idx]; c=0x20 SHALL emit a space, advance idx, and consume no input (1 cycle).
REQ-018 For c in 0x41..0x5A, SHALL match only cap_valid=1 && cap_flow==c; otherwise SHALL match only low_valid=1 && low_flow==c.
REQ-019 On a match, SHALL emit c and advance idx; on no match, SHALL hold idx with no output.
REQ-020 out_flow/out_valid SHALL be registered, asserting the cycle after the matching edge; out_flow SHALL hold its last value between strobes.
REQ-021 On a match or space at idx=L-1, SHALL go to DONE.
REQ-022 DONE (1 cycle) SHALL emit "!" (0x21) with out_valid=1 the following cycle, pulse done, and increment match_cnt (saturating at all-ones).
REQ-023 DONE SHALL go to SCAN with idx=0 if en=1, else to IDLE.
REQ-024 en=0 in SCAN SHALL go to IDLE at the next edge with idx=0, with no done and no count change.
REQ-025 A pattern of all spaces SHALL emit L spaces then "!" in L+1 cycles with no input.

Reset
REQ-026 rst_n=0 SHALL asynchronously force: state IDLE, idx=0, out_flow=0x20, out_valid=0, done=0, abort=0, match_cnt=0, latched length 0.
REQ-027 Pattern RAM SHALL be cleared to 0x00 by reset; reset mid-phrase SHALL discard progress with no output pulse.

Configuration
REQ-028 With macro CHECK_PHRASE_SEQ_TIMEOUT_EN defined: in SCAN with idx>0, TIMEOUT consecutive cycles without a match SHALL set idx=0 and pulse abort.
REQ-029 With CHECK_PHRASE_SEQ_TIMEOUT_EN undefined: SHALL have no timeout counter, tie abort to 0, and wait indefinitely.

Verification
REQ-030 Load "I Love You" (L=10), en=1, then feed I,L,o,v,e,Y,o,u on the correct streams with gaps -> out_flow sequence I,sp,L,o,v,e,sp,Y,o,u,!, one done, match_cnt=1.
REQ-031 Pattern "Ab", with 'A' on low_flow and 'b' on cap_flow -> no output; then 'A' on cap_flow and 'b' on low_flow -> A,b,!.
REQ-032 Assert rst_n=0 after 3 matched chars -> outputs at reset values immediately; en held, so after release the sequence restarts at idx 0.
REQ-033 pat_we with en=1 changing pat[0] -> RAM unchanged; the next phrase still matches the old pattern.
REQ-034 TIMEOUT=8, macro defined, stall 8 cycles after the first match -> abort pulse, idx=0; macro undefined -> no abort, completion after a 100-cycle stall.
REQ-035 CNT_W=2, complete 5 phrases -> match_cnt reads 1,2,3,3,3.
